intr_ctrl: RTL and testbench

INTR_CTRL -- requirements
Module: intr_ctrl

---
 rtl/intr_ctrl.sv | 141 ++++++++++++++
 tb/tb_intr_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intr_ctrl.sv
// Interrupt controller on the MCU IOBUS: edge-detected sources latch into PENDING,
// and the lowest enabled pending source is raised to the core and serviced without nesting.
module intr_ctrl #(
   parameter int          NUM_SRC   = 8,
   parameter logic [31:0] BASE_ADDR = 32'h1100_0100
) (
   input  logic               IC_clk,
   input  logic               IC_RST,
   input  logic [NUM_SRC-1:0] IC_SRC,
   input  logic [31:0]        IC_IOBUS_ADDR,
   input  logic [31:0]        IC_IOBUS_OUT,
   input  logic               IC_IOBUS_WR,
   output logic               IC_SEL,
   output logic [31:0]        IC_RD_DATA,
   output logic               IC_INTR
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ASSERT  = 2'd1,
      SERVICE = 2'd2
   } state_t;

   state_t             state;
   logic               intr_q;
   logic               armed;
   logic [NUM_SRC-1:0] src_q;
   logic [NUM_SRC-1:0] enable;
   logic [NUM_SRC-1:0] pending;
   logic [4:0]         active_id;

   logic               wr_en;
   logic [1:0]         reg_off;
   logic [4:0]         wr_id;
   logic [NUM_SRC-1:0] candidate;
   logic [31:0]        cand_ext;
   logic               cand_any;
   logic [4:0]         win_id;
   logic               claim_hit;
   logic               complete_hit;
   logic [NUM_SRC-1:0] rise;
   logic [NUM_SRC-1:0] clr;
   logic [NUM_SRC-1:0] pending_next;
   logic [31:0]        rd_data;
   logic               unused_bits;

   assign unused_bits = ^{IC_IOBUS_ADDR[1:0], IC_IOBUS_OUT};

   // Bus decode, priority pick and the pending-bit update; a new edge wins over any clear.
   always_comb begin
      IC_SEL    = (IC_IOBUS_ADDR[31:4] == BASE_ADDR[31:4]);
      wr_en     = IC_IOBUS_WR & IC_SEL;
      reg_off   = IC_IOBUS_ADDR[3:2];
      wr_id     = IC_IOBUS_OUT[4:0];
      candidate = pending & enable;
      cand_ext  = {{(32-NUM_SRC){1'b0}}, candidate};
      cand_any  = |candidate;

      win_id = 5'd0;
      for (int i = NUM_SRC-1; i >= 0; i--) begin
         if (candidate[i]) win_id = 5'(i);
      end

      claim_hit    = wr_en && (reg_off == 2'd2) && (state == ASSERT) && cand_ext[wr_id];
      complete_hit = wr_en && (reg_off == 2'd3) && (state == SERVICE) && (wr_id == active_id);

      rise = armed ? (IC_SRC & ~src_q) : '0;

      clr = '0;
      if (wr_en && (reg_off == 2'd1)) clr = IC_IOBUS_OUT[NUM_SRC-1:0];
      for (int i = 0; i < NUM_SRC; i++) begin
         if (claim_hit && (wr_id == 5'(i))) clr[i] = 1'b1;
      end

      pending_next = rise | (pending & ~clr);
   end

   // Register read mux; everything reads as zero when the window is not selected.
   always_comb begin
      rd_data = 32'd0;
      if (IC_SEL) begin
         case (reg_off)
            2'd0:    rd_data[NUM_SRC-1:0] = enable;
            2'd1:    rd_data[NUM_SRC-1:0] = pending;
            2'd2:    rd_data = {cand_any, 26'd0, win_id};
            default: begin
               rd_data[9:8] = state;
               rd_data[4:0] = active_id;
            end
         endcase
      end
   end

   assign IC_RD_DATA = rd_data;
   assign IC_INTR    = intr_q;

   // The first clock after reset only samples the sources, so lines already high are not edges.
   always_ff @(posedge IC_clk or negedge IC_RST) begin
      if (!IC_RST) begin
         state     <= IDLE;
         intr_q    <= 1'b0;
         armed     <= 1'b0;
         src_q     <= '0;
         enable    <= '0;
         pending   <= '0;
         active_id <= 5'd0;
      end else begin
         src_q   <= IC_SRC;
         armed   <= 1'b1;
         pending <= pending_next;
         if (wr_en && (reg_off == 2'd0)) enable <= IC_IOBUS_OUT[NUM_SRC-1:0];

         case (state)
            IDLE: begin
               if (cand_any) begin
                  state  <= ASSERT;
                  intr_q <= 1'b1;
               end
            end
            ASSERT: begin
               if (claim_hit) begin
                  state     <= SERVICE;
                  active_id <= wr_id;
                  intr_q    <= 1'b0;
               end else if (!cand_any) begin
                  state  <= IDLE;
                  intr_q <= 1'b0;
               end
            end
            SERVICE: begin
               if (complete_hit) state <= IDLE;
            end
            default: begin
               state  <= IDLE;
               intr_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_intr_ctrl.sv
// Scoreboarded bench for intr_ctrl: directed scenarios plus random bus/source traffic,
// all checked against a per-cycle reference model of the register and FSM rules.
module tb_intr_ctrl;

   localparam int          N       = 8;
   localparam logic [31:0] BASE    = 32'h1100_0100;
   localparam logic [31:0] A_EN    = BASE;
   localparam logic [31:0] A_PEND  = BASE + 32'd4;
   localparam logic [31:0] A_CLAIM = BASE + 32'd8;
   localparam logic [31:0] A_CMPL  = BASE + 32'd12;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic [N-1:0]  src;
   logic [31:0]   addr;
   logic [31:0]   wdata;
   logic          wr;
   logic          sel;
   logic [31:0]   rd;
   logic          intr;

   intr_ctrl #(.NUM_SRC(N), .BASE_ADDR(BASE)) dut (
      .IC_clk        (clk),
      .IC_RST        (rst_n),
      .IC_SRC        (src),
      .IC_IOBUS_ADDR (addr),
      .IC_IOBUS_OUT  (wdata),
      .IC_IOBUS_WR   (wr),
      .IC_SEL        (sel),
      .IC_RD_DATA    (rd),
      .IC_INTR       (intr)
   );

   typedef struct {
      int          cyc;
      int          kind;
      logic [31:0] exp;
      string       name;
   } exp_t;

   exp_t sbq[$];
   int   cyc      = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   bit   m_en[N];
   bit   m_pend[N];
   bit   m_srcq[N];
   bit   m_armed;
   int   m_state;
   int   m_active;

   function automatic int model_winner();
      for (int i = 0; i < N; i++) if (m_en[i] && m_pend[i]) return i;
      return -1;
   endfunction

   function automatic logic [31:0] model_read(logic [31:0] a);
      logic [31:0] r;
      int w;
      r = 32'd0;
      if (a[31:4] != BASE[31:4]) return 32'd0;
      case (a[3:2])
         2'd0: for (int i = 0; i < N; i++) r[i] = m_en[i];
         2'd1: for (int i = 0; i < N; i++) r[i] = m_pend[i];
         2'd2: begin
            w = model_winner();
            if (w >= 0) r = 32'h8000_0000 + 32'(w);
         end
         default: r = (32'(m_state) << 8) | 32'(m_active);
      endcase
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_en[i]   = 1'b0;
         m_pend[i] = 1'b0;
         m_srcq[i] = 1'b0;
      end
      m_armed  = 1'b0;
      m_state  = 0;
      m_active = 0;
   endtask

   // Advances the model by one clock using the inputs currently on the bus.
   task automatic model_step();
      bit n_pend[N];
      bit n_en[N];
      int n_state, n_active, off, id, w;
      bit we, claim;
      we       = wr && (addr[31:4] == BASE[31:4]);
      off      = int'(addr[3:2]);
      id       = int'(wdata[4:0]);
      w        = model_winner();
      n_state  = m_state;
      n_active = m_active;
      claim    = we && off == 2 && m_state == 1 && id < N && m_en[id] && m_pend[id];
      for (int i = 0; i < N; i++) begin
         n_pend[i] = m_pend[i];
         n_en[i]   = m_en[i];
         if (we && off == 1 && wdata[i]) n_pend[i] = 1'b0;
         if (claim && id == i) n_pend[i] = 1'b0;
         if (m_armed && src[i] && !m_srcq[i]) n_pend[i] = 1'b1;
         if (we && off == 0) n_en[i] = wdata[i];
      end
      case (m_state)
         0: if (w >= 0) n_state = 1;
         1: begin
            if (claim) begin
               n_state  = 2;
               n_active = id;
            end else if (w < 0) n_state = 0;
         end
         default: if (we && off == 3 && id == m_active) n_state = 0;
      endcase
      for (int i = 0; i < N; i++) begin
         m_pend[i] = n_pend[i];
         m_en[i]   = n_en[i];
         m_srcq[i] = src[i];
      end
      m_armed  = 1'b1;
      m_state  = n_state;
      m_active = n_active;
   endtask

   task automatic push(int kind, logic [31:0] v, string name);
      exp_t e;
      e.cyc  = cyc;
      e.kind = kind;
      e.exp  = v;
      e.name = name;
      sbq.push_back(e);
   endtask

   task automatic tick();
      if (!rst_n) model_reset();
      push(0, {31'd0, m_state == 1}, "intr");
      push(1, model_read(addr), "rd_data");
      push(2, {31'd0, addr[31:4] == BASE[31:4]}, "sel");
      @(posedge clk);
      if (rst_n) model_step();
      else       model_reset();
      cyc++;
      #1;
   endtask

   task automatic drive(logic w, logic [31:0] a, logic [31:0] d, logic [N-1:0] s);
      wr    = w;
      addr  = a;
      wdata = d;
      src   = s;
   endtask

   task automatic applyStimulus(logic w, logic [31:0] a, logic [31:0] d, logic [N-1:0] s);
      drive(w, a, d, s);
      tick();
   endtask

   task automatic checkOutput(exp_t e);
      logic [31:0] act;
      case (e.kind)
         0:       act = {31'd0, intr};
         1:       act = rd;
         default: act = {31'd0, sel};
      endcase
      n_checks++;
      if (act !== e.exp) begin
         n_errors++;
         $display("[TB] FAIL %s cyc=%0d actual=%h expected=%h", e.name, e.cyc, act, e.exp);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            exp_t e;
            e = sbq.pop_front();
            if (e.cyc < cyc) begin
               n_checks++;
               n_errors++;
               $display("[TB] FAIL stale_%s cyc=%0d actual=unchecked expected=%h", e.name, e.cyc, e.exp);
            end else begin
               checkOutput(e);
            end
         end
      end
   end

   initial begin
      logic [N-1:0] cur_src;
      rst_n = 1'b0;
      drive(1'b0, A_EN, 32'd0, '0);
      model_reset();
      @(posedge clk);
      #1;

      push(0, 32'd0, "reset_intr");
      push(1, 32'd0, "reset_enable");
      tick();
      drive(1'b0, A_PEND, 32'd0, '0);
      push(1, 32'd0, "reset_pending");
      tick();
      rst_n = 1'b1;
      applyStimulus(1'b0, A_EN, 32'd0, '0);

      // Basic latency and claim id
      applyStimulus(1'b1, A_EN, 32'h4, '0);
      drive(1'b0, A_CLAIM, 32'd0, 8'h04);
      push(0, 32'd0, "lat_n");
      tick();
      drive(1'b0, A_CLAIM, 32'd0, 8'h00);
      push(0, 32'd0, "lat_n1");
      tick();
      drive(1'b0, A_CLAIM, 32'd0, 8'h00);
      push(0, 32'd1, "lat_n2");
      push(1, 32'h8000_0002, "claim_id2");
      tick();
      applyStimulus(1'b1, A_CLAIM, 32'd2, '0);
      applyStimulus(1'b1, A_CMPL, 32'd2, '0);
      drive(1'b0, A_CMPL, 32'd0, '0);
      push(1, 32'h0000_0002, "cmpl_idle");
      tick();

      // Priority, ignored claim/complete, and re-assert after completion
      applyStimulus(1'b1, A_EN, 32'h28, '0);
      applyStimulus(1'b0, A_PEND, 32'd0, 8'h28);
      applyStimulus(1'b0, A_PEND, 32'd0, 8'h00);
      drive(1'b0, A_CLAIM, 32'd0, '0);
      push(0, 32'd1, "assert_35");
      push(1, 32'h8000_0003, "claim_id3");
      tick();
      applyStimulus(1'b1, A_CLAIM, 32'd6, '0);
      drive(1'b0, A_CMPL, 32'd0, '0);
      push(0, 32'd1, "claim6_ignored");
      push(1, 32'h0000_0102, "state_assert");
      tick();
      applyStimulus(1'b1, A_CLAIM, 32'd3, '0);
      drive(1'b0, A_CMPL, 32'd0, '0);
      push(0, 32'd0, "service_no_intr");
      push(1, 32'h0000_0203, "svc3");
      tick();
      applyStimulus(1'b1, A_CMPL, 32'd4, '0);
      drive(1'b0, A_CMPL, 32'd0, '0);
      push(0, 32'd0, "cmpl4_ignored_intr");
      push(1, 32'h0000_0203, "cmpl4_ignored");
      tick();
      applyStimulus(1'b1, A_CMPL, 32'd3, '0);
      drive(1'b0, A_CLAIM, 32'd0, '0);
      push(0, 32'd0, "idle_gap");
      tick();
      drive(1'b0, A_CLAIM, 32'd0, '0);
      push(0, 32'd1, "reassert");
      push(1, 32'h8000_0005, "claim_id5");
      tick();
      applyStimulus(1'b1, A_CLAIM, 32'd5, '0);
      applyStimulus(1'b1, A_CMPL, 32'd5, '0);
      applyStimulus(1'b1, A_EN, 32'd0, '0);

      // Same-cycle edge beats write-1-to-clear
      drive(1'b1, A_PEND, 32'h02, 8'h02);
      tick();
      drive(1'b0, A_PEND, 32'd0, 8'h02);
      push(1, 32'h0000_0002, "set_beats_w1c");
      tick();
      applyStimulus(1'b1, A_PEND, 32'h02, 8'h00);
      drive(1'b0, A_PEND, 32'd0, '0);
      push(1, 32'd0, "w1c_clears");
      tick();

      // Pending while disabled, then enabling raises the request
      applyStimulus(1'b0, A_PEND, 32'd0, 8'h01);
      applyStimulus(1'b0, A_PEND, 32'd0, 8'h00);
      drive(1'b0, A_PEND, 32'd0, '0);
      push(1, 32'h0000_0001, "pend_no_enable");
      push(0, 32'd0, "no_intr_disabled");
      tick();
      applyStimulus(1'b1, A_EN, 32'h01, '0);
      drive(1'b0, A_EN, 32'd0, '0);
      push(0, 32'd0, "en_plus1");
      tick();
      drive(1'b0, A_EN, 32'd0, '0);
      push(0, 32'd1, "en_plus2");
      tick();
      applyStimulus(1'b1, A_CLAIM, 32'd0, '0);

      // Asynchronous reset in the middle of service, sources held high across release
      applyStimulus(1'b0, A_EN, 32'd0, 8'hFF);
      drive(1'b0, A_EN, 32'd0, 8'hFF);
      rst_n = 1'b0;
      push(0, 32'd0, "rst_intr");
      push(1, 32'd0, "rst_enable");
      tick();
      drive(1'b0, A_PEND, 32'd0, 8'hFF);
      push(1, 32'd0, "rst_pending");
      tick();
      rst_n = 1'b1;
      applyStimulus(1'b0, A_PEND, 32'd0, 8'hFF);
      drive(1'b0, A_PEND, 32'd0, 8'hFF);
      push(1, 32'd0, "no_pend_after_rel");
      tick();
      drive(1'b0, A_CMPL, 32'd0, 8'hFF);
      push(1, 32'd0, "rst_cmpl");
      tick();
      applyStimulus(1'b0, A_PEND, 32'd0, '0);

      // Random traffic
      cur_src = '0;
      for (int k = 0; k < 800; k++) begin
         logic [31:0] a;
         logic [31:0] d;
         logic        w;
         int          w_id;
         for (int i = 0; i < N; i++) if ($urandom_range(7) == 0) cur_src[i] = ~cur_src[i];
         w = ($urandom_range(15) < 6);
         a = BASE + 32'($urandom_range(3)) * 32'd4 + 32'($urandom_range(3));
         if ($urandom_range(15) == 0) a = BASE + 32'h10 + 32'($urandom_range(255));
         d = $urandom;
         w_id = model_winner();
         if (a[3:2] == 2'd2 && w_id >= 0 && $urandom_range(1) == 0) d[4:0] = 5'(w_id);
         if (a[3:2] == 2'd3 && $urandom_range(1) == 0) d[4:0] = 5'(m_active);
         if (a[3:2] == 2'd1) d = d & $urandom & $urandom;
         rst_n = ($urandom_range(199) != 0);
         applyStimulus(w, a, d, cur_src);
      end
      rst_n = 1'b1;
      applyStimulus(1'b0, A_EN, 32'd0, '0);
      applyStimulus(1'b0, A_EN, 32'd0, '0);

      repeat (3) @(negedge clk);
      if (sbq.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("[TB] FAIL drain actual=%0d expected=0 pending expectations", sbq.size());
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
